// File: rtl/tt_spine_ctrl_if.sv
// Vertical spine bus between the spine controller (master) and the row muxes (slave).
interface tt_spine_ctrl_if #(
    parameter int S_IW = 31,
    parameter int S_OW = 26
);
    logic [S_IW-1:0] spine_iw;
    logic [S_OW-1:0] spine_ow;

    modport master (output spine_iw, input spine_ow);
    modport slave  (input spine_iw, output spine_ow);
endinterface

// File: rtl/tt_spine_ctrl.sv
// Spine-side controller: serial design select, glitch-free disable/select/settle/reset/run sequencing.
// Optional macro TT_SPINE_CTRL_SYNC_EN: two-flop synchronisers on the ctrl pads (single flop otherwise).
module tt_spine_ctrl #(
    parameter int N_IO          = 8,
    parameter int N_O           = 8,
    parameter int N_I           = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int RST_CYCLES    = 8,
    parameter int S_OW          = N_O + 2*N_IO + 2,
    parameter int S_IW          = N_I + N_IO + 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ctrl_sel_rst_n,
    input  logic                    ctrl_sel_inc,
    input  logic                    ctrl_ena,
    input  logic [N_I+N_IO-1:0]     pad_usr_in,
    output logic [N_O+2*N_IO-1:0]   pad_usr_out,
    tt_spine_ctrl_if.master         spine,
    output logic [9:0]              cur_sel,
    output logic                    running
);
    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESET  = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] RST_LAST    = 8'(RST_CYCLES - 1);

    logic [2:0]              pads_s;
    logic                    sel_rst_n_s, inc_s, ena_s, inc_s_d;
    logic [9:0]              sel_cnt, sel_q;
    logic [1:0]              state;
    logic [7:0]              cyc_cnt;
    logic                    spine_ena;
    logic [N_I+N_IO-1:0]     usr_drv;

`ifdef TT_SPINE_CTRL_SYNC_EN
    logic [2:0] pads_m;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pads_m <= '0;
            pads_s <= '0;
        end else begin
            pads_m <= {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena};
            pads_s <= pads_m;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pads_s <= '0;
        else        pads_s <= {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena};
    end
`endif

    assign sel_rst_n_s = pads_s[2];
    assign inc_s       = pads_s[1];
    assign ena_s       = pads_s[0];

    // Counter clear dominates a coincident increment edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_s_d <= 1'b0;
            sel_cnt <= '0;
        end else begin
            inc_s_d <= inc_s;
            if (!sel_rst_n_s)
                sel_cnt <= '0;
            else if (inc_s && !inc_s_d)
                sel_cnt <= sel_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_OFF;
            cyc_cnt <= '0;
            sel_q   <= '0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (ena_s && sel_rst_n_s) begin
                        state   <= ST_SETTLE;
                        sel_q   <= sel_cnt;
                        cyc_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!ena_s) begin
                        state <= ST_OFF;
                    end else if (cyc_cnt == SETTLE_LAST) begin
                        state   <= ST_RESET;
                        cyc_cnt <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                ST_RESET, ST_RUN: begin
                    // Any change of address request tears the design down before sel may move.
                    if (!ena_s || !sel_rst_n_s || (sel_cnt != sel_q)) begin
                        state <= ST_OFF;
                    end else if (state == ST_RESET) begin
                        if (cyc_cnt == RST_LAST)
                            state <= ST_RUN;
                        else
                            cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

    assign spine_ena = (state == ST_RESET) || (state == ST_RUN);

    always_comb begin
        usr_drv = '0;
        case (state)
            ST_RESET: begin
                usr_drv    = pad_usr_in;
                usr_drv[1] = 1'b0;
            end
            ST_RUN:  usr_drv = pad_usr_in;
            default: usr_drv = '0;
        endcase
    end

    assign spine.spine_iw = {1'b0, usr_drv, sel_q, spine_ena, 1'b0};
    assign pad_usr_out    = spine_ena ? spine.spine_ow[S_OW-2:1] : '0;
    assign cur_sel        = sel_q;
    assign running        = (state == ST_RUN);

    // Returned guard bits carry no information for the controller.
    logic unused_guards;
    assign unused_guards = spine.spine_ow[S_OW-1] ^ spine.spine_ow[0];
endmodule

// File: tb/tb_tt_spine_ctrl.sv
// Directed self-checking bench for tt_spine_ctrl (honours TT_SPINE_CTRL_SYNC_EN for latencies).
module tb_tt_spine_ctrl;
    localparam int SETTLE = 4;
    localparam int RSTC   = 8;
`ifdef TT_SPINE_CTRL_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
    logic [17:0] pad_usr_in;
    logic [23:0] pad_usr_out;
    logic [9:0]  cur_sel;
    logic        running;

    int total = 0;
    int bad   = 0;

    tt_spine_ctrl_if #(.S_IW(31), .S_OW(26)) sp ();

    tt_spine_ctrl #(
        .N_IO(8), .N_O(8), .N_I(10), .SETTLE_CYCLES(SETTLE), .RST_CYCLES(RSTC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena),
        .pad_usr_in     (pad_usr_in),
        .pad_usr_out    (pad_usr_out),
        .spine          (sp.master),
        .cur_sel        (cur_sel),
        .running        (running)
    );

    always #5 clk = ~clk;

    logic        s_ena, s_gh, s_gl;
    logic [9:0]  s_sel;
    logic [17:0] s_usr;
    assign s_gl  = sp.spine_iw[0];
    assign s_ena = sp.spine_iw[1];
    assign s_sel = sp.spine_iw[11:2];
    assign s_usr = sp.spine_iw[29:12];
    assign s_gh  = sp.spine_iw[30];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            ctrl_sel_inc = 1'b1; step(); step();
            ctrl_sel_inc = 1'b0; step(); step();
        end
    endtask

    task automatic wait_ena(input logic lvl, input int limit, output int n);
        n = 0;
        while (s_ena !== lvl && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic wait_run(input int limit, output int n);
        n = 0;
        while (running !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    // Background checks: sel frozen while ena high, and held stable long enough before ena rises.
    logic       prev_ena = 1'b0;
    logic [9:0] prev_sel = '0;
    int         stable   = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ena = 1'b0;
            prev_sel = s_sel;
            stable   = 0;
        end else begin
            if (prev_ena && s_ena) begin
                total++;
                assert (s_sel === prev_sel) else begin
                    bad++;
                    $error("FAIL sel_frozen observed=%0d expected=%0d", s_sel, prev_sel);
                end
            end else if (!prev_ena && s_ena) begin
                total++;
                assert (stable >= SETTLE) else begin
                    bad++;
                    $error("FAIL sel_settle observed=%0d expected>=%0d", stable, SETTLE);
                end
            end
            if (!s_ena)
                stable = (!prev_ena && s_sel === prev_sel) ? stable + 1 : 1;
            prev_ena = s_ena;
            prev_sel = s_sel;
        end
    end

    initial begin
        int n, rc, g;
        rst_n          = 1'b0;
        ctrl_sel_rst_n = 1'b1;
        ctrl_sel_inc   = 1'b0;
        ctrl_ena       = 1'b0;
        pad_usr_in     = 18'h3FFFF;
        sp.spine_ow    = 26'h3FFFFFF;
        repeat (3) step();

        chk("rst_spine_iw", 32'(sp.spine_iw), 32'h0);
        chk("rst_pad_out", 32'(pad_usr_out), 32'h0);
        chk("rst_cur_sel", 32'(cur_sel), 32'h0);
        chk("rst_running", 32'(running), 32'h0);

        rst_n = 1'b1;
        step(); step();

        // First enable at address 0
        ctrl_ena = 1'b1;
        wait_ena(1'b1, 50, n);
        chk("ena_rise_lat", n, D + SETTLE + 1);
        chk("sel0_cur_sel", 32'(cur_sel), 32'h0);
        chk("reset_usr", 32'(s_usr), 32'h3FFFD);
        chk("reset_pad_out", 32'(pad_usr_out), 32'hFFFFFF);
        chk("guards", 32'({s_gh, s_gl}), 32'h0);
        rc = 0; g = 0;
        while (running !== 1'b1 && g < 50) begin
            if (s_ena && s_usr[1] === 1'b0) rc++;
            step();
            g++;
        end
        chk("usr_rst_low_cycles", rc, RSTC);
        chk("run_running", 32'(running), 32'h1);
        chk("run_usr", 32'(s_usr), 32'h3FFFF);

        // Same-cycle passthrough in RUN
        pad_usr_in = 18'h00001; #1;
        chk("pass_in_clk_hi", 32'(s_usr), 32'h00001);
        pad_usr_in = 18'h00000; #1;
        chk("pass_in_clk_lo", 32'(s_usr), 32'h00000);
        sp.spine_ow = {1'b1, 24'h5A5A5A, 1'b1}; #1;
        chk("pass_out", 32'(pad_usr_out), 32'h5A5A5A);

        // Drop enable
        pad_usr_in = 18'h3FFFF;
        ctrl_ena = 1'b0;
        wait_ena(1'b0, 20, n);
        chk("ena_fall_lat", n, D + 1);
        chk("off_pad_out", 32'(pad_usr_out), 32'h0);
        chk("off_usr", 32'(s_usr), 32'h0);
        chk("off_running", 32'(running), 32'h0);

        // 37 increments while disabled
        pulse(37);
        repeat (3) step();
        ctrl_ena = 1'b1;
        wait_ena(1'b1, 50, n);
        chk("sel37_lat", n, D + SETTLE + 1);
        chk("sel37_cur_sel", 32'(cur_sel), 32'd37);
        chk("sel37_spine_sel", 32'(s_sel), 32'd37);
        wait_run(50, n);
        chk("sel37_rst_len", n, RSTC);

        // Increment while running tears down and re-sequences
        ctrl_sel_inc = 1'b1;
        n = 0;
        while (s_ena === 1'b1 && n < 20) begin
            step();
            n++;
            if (n == 2) ctrl_sel_inc = 1'b0;
        end
        chk("inc_run_drop_lat", n, D + 2);
        step(); step();
        wait_ena(1'b1, 50, n);
        chk("sel38_cur_sel", 32'(cur_sel), 32'd38);
        wait_run(50, n);
        chk("sel38_running", 32'(running), 32'h1);

        // Walk to 1023, then wrap to 0 with one more increment
        ctrl_ena = 1'b0;
        wait_ena(1'b0, 20, n);
        pulse(985);
        repeat (3) step();
        ctrl_ena = 1'b1;
        wait_ena(1'b1, 50, n);
        chk("sel1023_cur_sel", 32'(cur_sel), 32'd1023);
        wait_run(50, n);
        pulse(1);
        wait_ena(1'b1, 50, n);
        chk("wrap_cur_sel", 32'(cur_sel), 32'd0);
        chk("wrap_spine_sel", 32'(s_sel), 32'd0);
        wait_run(50, n);
        chk("wrap_running", 32'(running), 32'h1);

        // Counter clear has priority over a coincident increment edge
        ctrl_ena = 1'b0;
        wait_ena(1'b0, 20, n);
        pulse(5);
        step();
        ctrl_sel_rst_n = 1'b0;
        ctrl_sel_inc   = 1'b1;
        step();
        ctrl_sel_rst_n = 1'b1;
        step();
        ctrl_sel_inc = 1'b0;
        repeat (3) step();
        ctrl_ena = 1'b1;
        wait_ena(1'b1, 50, n);
        chk("selrst_prio_cur_sel", 32'(cur_sel), 32'd0);

        // Async reset while in RESET state
        ctrl_ena = 1'b0;
        wait_ena(1'b0, 20, n);
        pulse(3);
        repeat (3) step();
        ctrl_ena = 1'b1;
        wait_ena(1'b1, 50, n);
        chk("sel3_cur_sel", 32'(cur_sel), 32'd3);
        step(); step();
        chk("mid_reset_running", 32'(running), 32'h0);
        rst_n = 1'b0; #1;
        chk("async_spine_iw", 32'(sp.spine_iw), 32'h0);
        chk("async_pad_out", 32'(pad_usr_out), 32'h0);
        chk("async_cur_sel", 32'(cur_sel), 32'h0);
        chk("async_running", 32'(running), 32'h0);
        step(); step();
        rst_n = 1'b1;
        wait_ena(1'b1, 50, n);
        chk("restart_lat", n, D + SETTLE + 1);
        chk("restart_cur_sel", 32'(cur_sel), 32'h0);
        wait_run(50, n);
        chk("restart_rst_len", n, RSTC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
